cl_decode_stage: RTL and testbench
==================================

// Module: cl_decode_stage
// PURPOSE
//  Registered, handshaked decode stage between fetch and execute. Classifies each instruction_s
//  (load/store/mem/byte/writes-rf), holds it in one pipeline register and issues downstream with
//  valid/ready flow control. Tracks in-flight loads and stalls a dependent instruction
//  (load-use hazard) for LOAD_LAT cycles. Generalised successor of the combinational controller.
// PARAMETERS
//  RF_ADDR_W  5   width of the rd / rs_imm register-address fields
//  LOAD_LAT   2   cycles from load issue until its result can be consumed; scoreboard depth, >=1
//  CNT_W      16  width of the saturating stall-cycle performance counter
//  BYTE_OPS   1   1: kLBU/kSB decode as byte ops; 0: is_byte_op_o tied 0, kLBU/kSB decode as kLW/kSW
// PORTS
//  clk             in   1          core clock
//  n_reset         in   1          asynchronous, active-low reset
//  instr_valid_i   in   1          upstream instruction valid
//  instruction_i   in   instr_s    instruction from fetch
//  ready_o         out  1          stage can accept this cycle
//  flush_i         in   1          kill the held instruction (branch/jump redirect)
//  valid_o         out  1          decoded instruction available, no hazard
//  ready_i         in   1          execute accepts
//  instruction_o   out  instr_s    held instruction
//  ctrl_o          out  ctrl_s     {is_load, is_store, is_mem, is_byte, op_writes_rf}
//  hazard_o        out  1          held instruction blocked by a pending load
//  stall_cnt_o     out  CNT_W      cycles with hazard_o=1, saturating
// BEHAVIOUR
//  - Reset (n_reset=0, async): held-valid s_v=0, all scoreboard entries invalid, stall_cnt_o=0;
//    hence valid_o=0, hazard_o=0, ctrl_o=0, instruction_o=0. Reset mid-stall drops everything.
//  - Decode classes: load={kLW,kLBU}; store={kSW,kSB}; mem=load|store; byte={kLBU,kSB} (if BYTE_OPS);
//    writes_rf={kADDU,kSUBU,kSLLV,kSRAV,kSRLV,kAND,kOR,kNOR,kSLT,kSLTU,kMOV,kJALR,kLW,kLBU,kLBR}.
//    Unmatched opcodes decode all-zero. Decode is combinational on instruction_i, registered with it.
//  - hazard = s_v & any scoreboard entry e valid with e.rd == held rd or e.rd == held rs_imm
//    (both fields compared for every opcode; register 0 not special).
//  - valid_o = s_v & ~hazard; issue = valid_o & ready_i.
//  - ready_o = ~flush_i & (~s_v | issue) (combinational). accept = instr_valid_i & ready_o.
//  - Latency: accept in cycle N -> valid_o in N+1 at earliest; back-to-back throughput 1/cycle.
//  - Held register: flush_i -> s_v<=0 (priority over everything, no accept that cycle);
//    else accept -> load instruction+ctrl, s_v<=1; else issue -> s_v<=0; else hold unchanged.
//    Outputs stay stable while valid_o=1 & ready_i=0.
//  - Scoreboard: LOAD_LAT-entry shift register, shifts every cycle unconditionally;
//    entry[0] <= {issue & ctrl.is_load, held rd}; entry[k] <= entry[k-1]; last entry falls off.
//    A dependent instruction directly behind a load sees hazard_o=1 for exactly LOAD_LAT cycles.
//    flush_i does NOT clear the scoreboard (issued loads remain in flight).
//  - stall_cnt_o increments each cycle hazard_o=1, holds at 2^CNT_W-1.
//  - Downstream backpressure during a hazard: no effect on scoreboard aging.
// STRUCTURE
//  - Shared package: opcode patterns (kLW..kLBR), instr_s, ctrl_s {is_load,is_store,is_mem,is_byte,
//    op_writes_rf}, decode function decode_ctrl(instr_s) returning ctrl_s.
//  - One sub-module: cl_load_scoreboard #(RF_ADDR_W,LOAD_LAT) (clk,n_reset,push_v_i,push_rd_i,
//    rd_a_i,rd_b_i,hit_o). Top holds register, handshake, counter.
// TESTING
//  1 Reset: n_reset=0 with instr_valid_i=1 -> valid_o=0, ready_o=1, stall_cnt_o=0 after release.
//  2 LOAD_LAT=2: issue kLW rd=3 (ready_i=1), then kADDU rd=3 -> hazard_o=1 two cycles, issue 3rd cycle,
//    stall_cnt_o=2; same with rd=4,rs=5 -> no stall.
//  3 Backpressure: ready_i=0 for 5 cycles with kSW held -> instruction_o/ctrl_o stable, ready_o=0,
//    is_store=1,is_mem=1; ready_i=1 -> issue, next instr accepted same cycle.
//  4 Flush: flush_i=1 with held kLBU and instr_valid_i=1 -> next cycle s_v=0, valid_o=0, input not
//    accepted; pending load in scoreboard still stalls a later dependent op.
//  5 BYTE_OPS=0: kLBU -> is_load=1,is_byte=0; BYTE_OPS=1 -> is_byte=1; unknown opcode -> ctrl_o=0.
//  6 CNT_W=2: 5 hazard cycles -> stall_cnt_o saturates at 3; reset mid-stall -> hazard_o=0 at once.

Source files
------------

// File: rtl/cl_decode_stage_pkg.sv
// Shared types for the decode stage: opcode patterns, instruction and control
// records, and the combinational classifier used at the stage input.
package cl_decode_stage_pkg;

   localparam int OP_W = 6;
   localparam int RF_W = 5;

   localparam logic [OP_W-1:0] kADDU = 6'h01;
   localparam logic [OP_W-1:0] kSUBU = 6'h02;
   localparam logic [OP_W-1:0] kSLLV = 6'h03;
   localparam logic [OP_W-1:0] kSRAV = 6'h04;
   localparam logic [OP_W-1:0] kSRLV = 6'h05;
   localparam logic [OP_W-1:0] kAND  = 6'h06;
   localparam logic [OP_W-1:0] kOR   = 6'h07;
   localparam logic [OP_W-1:0] kNOR  = 6'h08;
   localparam logic [OP_W-1:0] kSLT  = 6'h09;
   localparam logic [OP_W-1:0] kSLTU = 6'h0A;
   localparam logic [OP_W-1:0] kMOV  = 6'h0B;
   localparam logic [OP_W-1:0] kJALR = 6'h0C;
   localparam logic [OP_W-1:0] kLW   = 6'h10;
   localparam logic [OP_W-1:0] kLBU  = 6'h11;
   localparam logic [OP_W-1:0] kLBR  = 6'h12;
   localparam logic [OP_W-1:0] kSW   = 6'h18;
   localparam logic [OP_W-1:0] kSB   = 6'h19;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [RF_W-1:0] rd;
      logic [RF_W-1:0] rs_imm;
   } instr_s;

   typedef struct packed {
      logic is_load;
      logic is_store;
      logic is_mem;
      logic is_byte;
      logic op_writes_rf;
   } ctrl_s;

   // Unlisted opcodes fall through to an all-zero record.
   function automatic ctrl_s decode_ctrl(input instr_s instr);
      ctrl_s c;
      c              = '0;
      c.is_load      = instr.op inside {kLW, kLBU};
      c.is_store     = instr.op inside {kSW, kSB};
      c.is_mem       = c.is_load | c.is_store;
      c.is_byte      = instr.op inside {kLBU, kSB};
      c.op_writes_rf = instr.op inside {kADDU, kSUBU, kSLLV, kSRAV, kSRLV,
                                        kAND, kOR, kNOR, kSLT, kSLTU, kMOV,
                                        kJALR, kLW, kLBU, kLBR};
      return c;
   endfunction

endpackage

// File: rtl/cl_load_scoreboard.sv
// Tracks destination registers of issued loads for LOAD_LAT cycles and flags
// any match against the two register fields of the held instruction.
module cl_load_scoreboard #(
   parameter int RF_ADDR_W = 5,
   parameter int LOAD_LAT  = 2
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 push_v_i,
   input  logic [RF_ADDR_W-1:0] push_rd_i,
   input  logic [RF_ADDR_W-1:0] rd_a_i,
   input  logic [RF_ADDR_W-1:0] rd_b_i,
   output logic                 hit_o
);

   logic                 sb_v  [LOAD_LAT];
   logic [RF_ADDR_W-1:0] sb_rd [LOAD_LAT];

   // Ages every cycle regardless of downstream stalls; the oldest entry drops off.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int k = 0; k < LOAD_LAT; k++) begin
            sb_v[k]  <= 1'b0;
            sb_rd[k] <= '0;
         end
      end else begin
         sb_v[0]  <= push_v_i;
         sb_rd[0] <= push_rd_i;
         for (int k = 1; k < LOAD_LAT; k++) begin
            sb_v[k]  <= sb_v[k-1];
            sb_rd[k] <= sb_rd[k-1];
         end
      end
   end

   always_comb begin
      hit_o = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         hit_o = hit_o | (sb_v[k] & ((sb_rd[k] == rd_a_i) | (sb_rd[k] == rd_b_i)));
      end
   end

endmodule

// File: rtl/cl_decode_stage.sv
// Registered decode stage: classifies the incoming instruction, holds it in a
// single pipeline register and issues it once no in-flight load blocks it.
module cl_decode_stage
   import cl_decode_stage_pkg::*;
#(
   parameter int RF_ADDR_W = RF_W,
   parameter int LOAD_LAT  = 2,
   parameter int CNT_W     = 16,
   parameter int BYTE_OPS  = 1
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             instr_valid_i,
   input  instr_s           instruction_i,
   output logic             ready_o,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output instr_s           instruction_o,
   output ctrl_s            ctrl_o,
   output logic             hazard_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   logic             s_v;
   instr_s           s_instr;
   ctrl_s            s_ctrl;
   ctrl_s            ctrl_d;
   logic             sb_hit;
   logic             issue;
   logic             accept;
   logic [CNT_W-1:0] stall_cnt;

   always_comb begin
      ctrl_d = decode_ctrl(instruction_i);
      if (BYTE_OPS == 0) begin
         ctrl_d.is_byte = 1'b0;
      end
   end

   // Handshake: a transfer happens on a cycle where valid and ready are both
   // high; valid never waits for ready, and the held data stays frozen while
   // valid_o=1 and ready_i=0. ready_o also opens on the cycle the held entry issues.
   assign hazard_o = s_v & sb_hit;
   assign valid_o  = s_v & ~sb_hit;
   assign issue    = valid_o & ready_i;
   assign ready_o  = ~flush_i & (~s_v | issue);
   assign accept   = instr_valid_i & ready_o;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         s_v     <= 1'b0;
         s_instr <= '0;
         s_ctrl  <= '0;
      end else if (flush_i) begin
         s_v <= 1'b0;
      end else if (accept) begin
         s_v     <= 1'b1;
         s_instr <= instruction_i;
         s_ctrl  <= ctrl_d;
      end else if (issue) begin
         s_v <= 1'b0;
      end
   end

   cl_load_scoreboard #(
      .RF_ADDR_W (RF_ADDR_W),
      .LOAD_LAT  (LOAD_LAT)
   ) u_scoreboard (
      .clk       (clk),
      .n_reset   (n_reset),
      .push_v_i  (issue & s_ctrl.is_load),
      .push_rd_i (s_instr.rd),
      .rd_a_i    (s_instr.rd),
      .rd_b_i    (s_instr.rs_imm),
      .hit_o     (sb_hit)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         stall_cnt <= '0;
      end else if (hazard_o && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign instruction_o = s_instr;
   assign ctrl_o        = s_ctrl;
   assign stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_cl_decode_stage.sv
// Directed bench for cl_decode_stage: a decode vector table plus hand-written
// load-use, backpressure, flush and counter-saturation sequences.
module tb_cl_decode_stage;
  import cl_decode_stage_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   n_reset;
  logic   instr_valid_i;
  instr_s instruction_i;
  logic   flush_i;
  logic   ready_i;

  // instance a: defaults; b: BYTE_OPS=0; c: CNT_W=2, LOAD_LAT=5
  logic        a_ready, a_valid, a_hazard;
  instr_s      a_instr;
  ctrl_s       a_ctrl;
  logic [15:0] a_cnt;
  logic        b_ready, b_valid, b_hazard;
  instr_s      b_instr;
  ctrl_s       b_ctrl;
  logic [15:0] b_cnt;
  logic        c_ready, c_valid, c_hazard;
  instr_s      c_instr;
  ctrl_s       c_ctrl;
  logic [1:0]  c_cnt;

  cl_decode_stage u_a (
    .clk(clk), .n_reset(n_reset), .instr_valid_i(instr_valid_i), .instruction_i(instruction_i),
    .ready_o(a_ready), .flush_i(flush_i), .valid_o(a_valid), .ready_i(ready_i),
    .instruction_o(a_instr), .ctrl_o(a_ctrl), .hazard_o(a_hazard), .stall_cnt_o(a_cnt)
  );

  cl_decode_stage #(.BYTE_OPS(0)) u_b (
    .clk(clk), .n_reset(n_reset), .instr_valid_i(instr_valid_i), .instruction_i(instruction_i),
    .ready_o(b_ready), .flush_i(flush_i), .valid_o(b_valid), .ready_i(ready_i),
    .instruction_o(b_instr), .ctrl_o(b_ctrl), .hazard_o(b_hazard), .stall_cnt_o(b_cnt)
  );

  cl_decode_stage #(.CNT_W(2), .LOAD_LAT(5)) u_c (
    .clk(clk), .n_reset(n_reset), .instr_valid_i(instr_valid_i), .instruction_i(instruction_i),
    .ready_o(c_ready), .flush_i(flush_i), .valid_o(c_valid), .ready_i(ready_i),
    .instruction_o(c_instr), .ctrl_o(c_ctrl), .hazard_o(c_hazard), .stall_cnt_o(c_cnt)
  );

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  typedef struct {
    instr_s instr;
    ctrl_s  exp_a;
    ctrl_s  exp_b;
  } vec_t;

  vec_t vecs[19];

  function automatic instr_s mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs);
    instr_s t;
    t.op     = op;
    t.rd     = rd;
    t.rs_imm = rs;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset       = 1'b0;
    instr_valid_i = 1'b0;
    flush_i       = 1'b0;
    ready_i       = 1'b1;
    instruction_i = '0;
    tick();
    tick();
    n_reset = 1'b1;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // ctrl packing {is_load,is_store,is_mem,is_byte,op_writes_rf}
    vecs[0]  = '{mk(kADDU, 5'd1,  5'd1),  5'b00001, 5'b00001};
    vecs[1]  = '{mk(kSUBU, 5'd2,  5'd2),  5'b00001, 5'b00001};
    vecs[2]  = '{mk(kSLLV, 5'd3,  5'd3),  5'b00001, 5'b00001};
    vecs[3]  = '{mk(kSRAV, 5'd4,  5'd4),  5'b00001, 5'b00001};
    vecs[4]  = '{mk(kSRLV, 5'd5,  5'd5),  5'b00001, 5'b00001};
    vecs[5]  = '{mk(kAND,  5'd6,  5'd6),  5'b00001, 5'b00001};
    vecs[6]  = '{mk(kOR,   5'd7,  5'd7),  5'b00001, 5'b00001};
    vecs[7]  = '{mk(kNOR,  5'd8,  5'd8),  5'b00001, 5'b00001};
    vecs[8]  = '{mk(kSLT,  5'd9,  5'd9),  5'b00001, 5'b00001};
    vecs[9]  = '{mk(kSLTU, 5'd10, 5'd10), 5'b00001, 5'b00001};
    vecs[10] = '{mk(kMOV,  5'd11, 5'd11), 5'b00001, 5'b00001};
    vecs[11] = '{mk(kJALR, 5'd12, 5'd12), 5'b00001, 5'b00001};
    vecs[12] = '{mk(kLW,   5'd13, 5'd13), 5'b10101, 5'b10101};
    vecs[13] = '{mk(kLBU,  5'd14, 5'd14), 5'b10111, 5'b10101};
    vecs[14] = '{mk(kLBR,  5'd15, 5'd15), 5'b00001, 5'b00001};
    vecs[15] = '{mk(kSW,   5'd16, 5'd16), 5'b01100, 5'b01100};
    vecs[16] = '{mk(kSB,   5'd17, 5'd17), 5'b01110, 5'b01100};
    vecs[17] = '{mk(6'h00, 5'd18, 5'd18), 5'b00000, 5'b00000};
    vecs[18] = '{mk(6'h3F, 5'd19, 5'd19), 5'b00000, 5'b00000};

    // reset with valid input present
    n_reset       = 1'b0;
    instr_valid_i = 1'b1;
    instruction_i = mk(kLW, 5'd3, 5'd1);
    flush_i       = 1'b0;
    ready_i       = 1'b1;
    tick();
    tick();
    check("rst_valid", a_valid, 1'b0);
    check("rst_hazard", a_hazard, 1'b0);
    check("rst_ctrl", a_ctrl, 5'b00000);
    check("rst_instr", a_instr, 16'h0000);
    n_reset       = 1'b1;
    instr_valid_i = 1'b0;
    #1;
    check("rst_ready", a_ready, 1'b1);
    check("rst_cnt", a_cnt, 16'd0);
    check("rst_valid_after", a_valid, 1'b0);

    // decode table, back-to-back one per cycle
    do_reset();
    for (int i = 0; i < 19; i++) begin
      instruction_i = vecs[i].instr;
      instr_valid_i = 1'b1;
      tick();
      check($sformatf("vec%0d_valid", i), a_valid, 1'b1);
      check($sformatf("vec%0d_instr", i), a_instr, vecs[i].instr);
      check($sformatf("vec%0d_ctrl", i), a_ctrl, vecs[i].exp_a);
      check($sformatf("vec%0d_ctrl_nobyte", i), b_ctrl, vecs[i].exp_b);
    end
    instr_valid_i = 1'b0;
    tick();
    check("vec_drain_valid", a_valid, 1'b0);

    // load-use hazard, then independent op
    do_reset();
    instruction_i = mk(kLW, 5'd3, 5'd1);
    instr_valid_i = 1'b1;
    tick();
    check("lu_load_valid", a_valid, 1'b1);
    instruction_i = mk(kADDU, 5'd3, 5'd7);
    tick();
    instr_valid_i = 1'b0;
    check("lu_hazard1", a_hazard, 1'b1);
    check("lu_valid1", a_valid, 1'b0);
    check("lu_ready1", a_ready, 1'b0);
    tick();
    check("lu_hazard2", a_hazard, 1'b1);
    tick();
    check("lu_hazard3", a_hazard, 1'b0);
    check("lu_valid3", a_valid, 1'b1);
    check("lu_cnt", a_cnt, 16'd2);
    tick();
    check("lu_done", a_valid, 1'b0);
    tick();
    tick();
    instruction_i = mk(kLW, 5'd3, 5'd1);
    instr_valid_i = 1'b1;
    tick();
    instruction_i = mk(kADDU, 5'd4, 5'd5);
    tick();
    instr_valid_i = 1'b0;
    check("nodep_hazard", a_hazard, 1'b0);
    check("nodep_valid", a_valid, 1'b1);
    tick();
    check("nodep_cnt", a_cnt, 16'd2);

    // backpressure with a held store
    do_reset();
    ready_i       = 1'b0;
    instruction_i = mk(kSW, 5'd8, 5'd9);
    instr_valid_i = 1'b1;
    tick();
    instruction_i = mk(kADDU, 5'd10, 5'd11);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), a_valid, 1'b1);
      check($sformatf("bp%0d_ready", k), a_ready, 1'b0);
      check($sformatf("bp%0d_instr", k), a_instr, mk(kSW, 5'd8, 5'd9));
      check($sformatf("bp%0d_ctrl", k), a_ctrl, 5'b01100);
      tick();
    end
    ready_i = 1'b1;
    #1;
    check("bp_release_ready", a_ready, 1'b1);
    tick();
    instr_valid_i = 1'b0;
    check("bp_next_instr", a_instr, mk(kADDU, 5'd10, 5'd11));
    check("bp_next_valid", a_valid, 1'b1);
    tick();

    // flush of a held load with an in-flight load behind it
    do_reset();
    instruction_i = mk(kLW, 5'd14, 5'd1);
    instr_valid_i = 1'b1;
    tick();
    check("fl_lw_valid", a_valid, 1'b1);
    instruction_i = mk(kLBU, 5'd12, 5'd13);
    tick();
    check("fl_held_lbu", a_instr, mk(kLBU, 5'd12, 5'd13));
    flush_i       = 1'b1;
    instruction_i = mk(kADDU, 5'd20, 5'd21);
    #1;
    check("fl_ready", a_ready, 1'b0);
    tick();
    flush_i = 1'b0;
    check("fl_valid", a_valid, 1'b0);
    check("fl_not_accepted", a_instr, mk(kLBU, 5'd12, 5'd13));
    instruction_i = mk(kADDU, 5'd15, 5'd14);
    tick();
    instr_valid_i = 1'b0;
    check("fl_c_hazard", c_hazard, 1'b1);
    check("fl_c_valid", c_valid, 1'b0);
    check("fl_a_hazard", a_hazard, 1'b0);
    check("fl_a_valid", a_valid, 1'b1);
    tick();
    tick();
    tick();
    check("fl_c_clear", c_hazard, 1'b0);
    check("fl_c_issue", c_valid, 1'b1);
    tick();

    // saturating counter (CNT_W=2, LOAD_LAT=5) and reset mid-stall
    do_reset();
    instruction_i = mk(kLW, 5'd3, 5'd1);
    instr_valid_i = 1'b1;
    tick();
    instruction_i = mk(kADDU, 5'd3, 5'd0);
    tick();
    instr_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sat%0d_hazard", k), c_hazard, 1'b1);
      tick();
    end
    check("sat_clear", c_hazard, 1'b0);
    check("sat_valid", c_valid, 1'b1);
    check("sat_cnt", c_cnt, 2'd3);
    check("sat_a_cnt", a_cnt, 16'd2);
    tick();
    instruction_i = mk(kLW, 5'd7, 5'd1);
    instr_valid_i = 1'b1;
    tick();
    instruction_i = mk(kADDU, 5'd7, 5'd2);
    tick();
    instr_valid_i = 1'b0;
    check("mid_hazard", c_hazard, 1'b1);
    tick();
    n_reset = 1'b0;
    #1;
    check("mid_rst_hazard", c_hazard, 1'b0);
    check("mid_rst_valid", c_valid, 1'b0);
    check("mid_rst_cnt", c_cnt, 2'd0);
    check("mid_rst_ctrl", c_ctrl, 5'b00000);
    tick();
    n_reset = 1'b1;
    tick();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
